// File: rtl/moonbase_sram_bridge_pkg.sv
// Shared widths, CPU bus bit positions and the bridge state type.
package moonbase_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 4;

    // Bit positions on the CPU's multiplexed output bus
    localparam int BUS_ASTB   = 7;
    localparam int BUS_WSTB_N = 5;
    localparam int BUS_DSTB   = 4;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_e;

endpackage

// File: rtl/moonbase_sram_bridge_if.sv
// Host/CPU-facing signal bundle of the SRAM bridge.
// The master side is the CPU plus host. The slave side is the bridge.
interface moonbase_sram_bridge_if;
    import moonbase_pkg::*;

    logic [7:0]        cpu_bus;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rst;

    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_done;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_overflow;

    modport master (
        output cpu_bus, load_valid, load_addr, load_data, load_done, out_ready,
        input  cpu_rdata, cpu_rst, load_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  cpu_bus, load_valid, load_addr, load_data, load_done, out_ready,
        output cpu_rdata, cpu_rst, load_ready, out_valid, out_data, out_overflow
    );

endinterface

// File: rtl/moonbase_sram_bridge_out_fifo.sv
// Small output FIFO for captured CPU writes.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
// Otherwise it is dropped, which sets the sticky overflow flag.
module moonbase_out_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] store [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              take;
    logic              accept;

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign take   = pop & ~empty;
    assign accept = push & (~full | take);
    assign head   = store[rd_ptr];

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (take)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, take})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push & ~accept) overflow <= 1'b1;
        end
    end

    // Entry storage; contents are meaningless while empty and are masked by the top
    always_ff @(posedge clk) begin
        if (accept) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/moonbase_sram_bridge.sv
// Memory-side companion for moonbase_cpu_4bit. It serves a 128x4 memory over the CPU's
// multiplexed bus, loads the program from a host while the CPU is held in reset,
// and mirrors CPU writes to OUT_ADDR into an output FIFO.
module moonbase_sram_bridge
    import moonbase_pkg::*;
#(
    parameter logic [ADDR_W-1:0] OUT_ADDR   = 7'h5E,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    moonbase_sram_bridge_if.slave  bus_if
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state;
    state_e            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              astb;
    logic              run_active;
    logic              load_fire;
    logic              wr_now;
    logic              wr_prev;
    logic              push_req;
    logic              pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_full_unused;
    logic              fifo_overflow;

    assign astb       = bus_if.cpu_bus[BUS_ASTB];
    assign run_active = (state == ST_RUN) & ~rst;
    assign load_fire  = bus_if.load_valid & bus_if.load_ready;
    assign wr_now     = run_active & ~astb & ~bus_if.cpu_bus[BUS_WSTB_N];
    assign push_req   = wr_now & ~wr_prev & (addr_q == OUT_ADDR);

    // Reads are transparent: a strobed address is used directly, otherwise the latched one
    assign rd_addr          = astb ? bus_if.cpu_bus[ADDR_W-1:0] : addr_q;
    assign bus_if.cpu_rdata = mem[rd_addr];

    assign bus_if.out_valid    = ~fifo_empty & ~rst;
    assign bus_if.out_data     = bus_if.out_valid ? fifo_head : '0;
    assign bus_if.out_overflow = fifo_overflow;
    assign pop                 = bus_if.out_valid & bus_if.out_ready;

    // Load/run state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_next;
    end

    // Next state and handshake/reset outputs; reset forces the CPU into reset immediately
    always_comb begin
        state_next        = state;
        bus_if.cpu_rst    = 1'b1;
        bus_if.load_ready = 1'b0;
        case (state)
            ST_LOAD: begin
                bus_if.load_ready = ~rst;
                if (bus_if.load_done) state_next = ST_RUN;
            end
            ST_RUN: begin
                bus_if.cpu_rst = rst;
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // Address latch and write-strobe history for capture edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wr_prev <= 1'b0;
        end else begin
            wr_prev <= wr_now;
            if (run_active && astb) addr_q <= bus_if.cpu_bus[ADDR_W-1:0];
        end
    end

    // Memory array: host loads in LOAD, level-sensitive CPU writes in RUN; never cleared
    always_ff @(posedge clk) begin
        if (load_fire)   mem[bus_if.load_addr] <= bus_if.load_data;
        else if (wr_now) mem[addr_q]           <= bus_if.cpu_bus[DATA_W-1:0];
    end

    moonbase_out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (bus_if.cpu_bus[DATA_W-1:0]),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow)
    );

endmodule

// File: tb/tb_moonbase_sram_bridge.sv
// Directed bench for moonbase_sram_bridge: load, run, capture, overflow and reset.
module tb_moonbase_sram_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    moonbase_sram_bridge_if bif ();

    moonbase_sram_bridge dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One capture write to the currently latched address, strobe released afterwards
    task automatic cap_write(input logic [3:0] d);
        bif.cpu_bus = {4'h0, d};
        tick();
        bif.cpu_bus = 8'h20;
        tick();
    endtask

    initial begin
        bif.cpu_bus    = 8'h20;
        bif.load_valid = 1'b0;
        bif.load_addr  = '0;
        bif.load_data  = '0;
        bif.load_done  = 1'b0;
        bif.out_ready  = 1'b0;

        // Reset for two cycles
        tick();
        tick();
        check("rst_cpu_rst", bif.cpu_rst, 1);
        check("rst_load_ready", bif.load_ready, 0);
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_out_data", bif.out_data, 0);
        check("rst_overflow", bif.out_overflow, 0);
        rst = 1'b0;
        settle();
        check("load_ready_in_load", bif.load_ready, 1);

        // Program load
        bif.load_valid = 1'b1;
        bif.load_addr  = 7'h00;
        bif.load_data  = 4'h8;
        tick();
        bif.load_addr  = 7'h01;
        bif.load_data  = 4'h3;
        tick();
        bif.load_valid = 1'b0;
        bif.load_done  = 1'b1;
        settle();
        check("cpu_rst_at_done", bif.cpu_rst, 1);
        tick();
        bif.load_done = 1'b0;
        settle();
        check("cpu_rst_in_run", bif.cpu_rst, 0);
        check("load_ready_in_run", bif.load_ready, 0);

        // Load attempt while running must not touch memory
        bif.load_valid = 1'b1;
        bif.load_addr  = 7'h01;
        bif.load_data  = 4'hF;
        tick();
        bif.load_valid = 1'b0;

        // Zero-latency reads and address latch
        bif.cpu_bus = 8'h80;
        settle();
        check("read_mem0", bif.cpu_rdata, 8);
        bif.cpu_bus = 8'h81;
        settle();
        check("read_mem1", bif.cpu_rdata, 3);
        tick();
        bif.cpu_bus = 8'h20;
        settle();
        check("read_latched", bif.cpu_rdata, 3);
        tick();

        // Plain write to 0x10
        bif.cpu_bus = 8'h90;
        tick();
        bif.cpu_bus = 8'h09;
        tick();
        tick();
        tick();
        bif.cpu_bus = 8'h20;
        settle();
        check("plain_write_latched", bif.cpu_rdata, 9);
        check("plain_no_capture", bif.out_valid, 0);
        tick();
        bif.cpu_bus = 8'h90;
        settle();
        check("plain_write_strobed", bif.cpu_rdata, 9);
        tick();

        // Capture write to OUT_ADDR held three cycles gives a single push
        bif.cpu_bus = 8'hDE;
        tick();
        bif.cpu_bus = 8'h07;
        tick();
        tick();
        tick();
        bif.cpu_bus = 8'h20;
        settle();
        check("cap_valid", bif.out_valid, 1);
        check("cap_data", bif.out_data, 7);
        check("cap_mem", bif.cpu_rdata, 7);
        bif.out_ready = 1'b1;
        tick();
        bif.out_ready = 1'b0;
        settle();
        check("cap_single_push", bif.out_valid, 0);

        // Overflow: five captures into a four-entry FIFO
        for (int d = 1; d <= 5; d++) cap_write(4'(d));
        check("ovf_set", bif.out_overflow, 1);
        check("ovf_head", bif.out_data, 1);
        bif.out_ready = 1'b1;
        settle();
        for (int d = 1; d <= 4; d++) begin
            check($sformatf("ovf_pop%0d", d), bif.out_data, d);
            tick();
        end
        check("ovf_drained_valid", bif.out_valid, 0);
        check("ovf_drained_data", bif.out_data, 0);
        check("ovf_sticky", bif.out_overflow, 1);
        bif.out_ready = 1'b0;

        // Reset in RUN with a non-empty FIFO
        cap_write(4'hB);
        check("pre_rst_valid", bif.out_valid, 1);
        rst = 1'b1;
        settle();
        check("mid_rst_cpu_rst", bif.cpu_rst, 1);
        check("mid_rst_out_valid", bif.out_valid, 0);
        tick();
        rst = 1'b0;
        settle();
        check("post_rst_cpu_rst", bif.cpu_rst, 1);
        check("post_rst_out_valid", bif.out_valid, 0);
        check("post_rst_overflow", bif.out_overflow, 0);
        check("post_rst_load_ready", bif.load_ready, 1);
        bif.cpu_bus = 8'h81;
        settle();
        check("mem_retained", bif.cpu_rdata, 3);
        bif.load_done = 1'b1;
        tick();
        bif.load_done = 1'b0;

        // Full FIFO plus same-cycle pop and push
        bif.cpu_bus = 8'hDE;
        tick();
        bif.cpu_bus = 8'h20;
        tick();
        for (int d = 1; d <= 4; d++) cap_write(4'(d));
        bif.cpu_bus   = 8'h0A;
        bif.out_ready = 1'b1;
        tick();
        bif.cpu_bus = 8'h20;
        settle();
        check("fullpop_no_ovf", bif.out_overflow, 0);
        check("fullpop_d2", bif.out_data, 2);
        tick();
        check("fullpop_d3", bif.out_data, 3);
        tick();
        check("fullpop_d4", bif.out_data, 4);
        tick();
        check("fullpop_dA", bif.out_data, 4'hA);
        tick();
        check("fullpop_empty", bif.out_valid, 0);
        check("fullpop_ovf_end", bif.out_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
